// File: rtl/atable_fetch_if.sv
// atable_fetch_if: background and debug request/response bundle for the attribute-table fetch controller
interface atable_fetch_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              bg_req;
  logic              bg_nt;
  logic [4:0]        bg_tcol;
  logic [4:0]        bg_trow;
  logic              bg_ack;
  logic [1:0]        bg_pal;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output bg_req, bg_nt, bg_tcol, bg_trow, dbg_req, dbg_addr,
    input  bg_ack, bg_pal, dbg_ack, dbg_data
  );
  modport slave (
    input  bg_req, bg_nt, bg_tcol, bg_trow, dbg_req, dbg_addr,
    output bg_ack, bg_pal, dbg_ack, dbg_data
  );
endinterface

// File: rtl/atable_fetch_ctrl.sv
// atable_fetch_ctrl: round-robin fetch sequencer for the attribute-table ROM; ATABLE_CACHE_EN adds a one-entry bg cache
module atable_fetch_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int TROW_MAX = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  atable_fetch_if.slave     bus,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_dout,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, RD, CAP, ACK} state_t;
  localparam logic [4:0] TROW_LIM = 5'(TROW_MAX);

  state_t            r_state, w_state;
  logic              r_gnt_dbg, w_gnt_dbg;
  logic              r_last_dbg, w_last_dbg;
  logic [1:0]        r_sel, w_sel;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr;
  logic              r_bg_ack, w_bg_ack;
  logic [1:0]        r_bg_pal, w_bg_pal;
  logic              r_dbg_ack, w_dbg_ack;
  logic [DATA_W-1:0] r_dbg_data, w_dbg_data;
  logic              r_busy;
  logic [ADDR_W-1:0] w_bg_addr;
  logic [1:0]        w_bg_sel;
  logic              w_oor;
  logic              w_pick_dbg;
  logic              w_unused;
`ifdef ATABLE_CACHE_EN
  logic              r_c_vld, w_c_vld;
  logic [ADDR_W-1:0] r_c_tag, w_c_tag;
  logic [DATA_W-1:0] r_c_data, w_c_data;
`endif

  function automatic logic [1:0] f_pal(input logic [DATA_W-1:0] b, input logic [1:0] s);
    return b[{s, 1'b0} +: 2];
  endfunction

  assign w_bg_addr  = {bus.bg_nt, bus.bg_trow[4:2], bus.bg_tcol[4:2]};
  assign w_bg_sel   = {bus.bg_trow[1], bus.bg_tcol[1]};
  assign w_oor      = bus.bg_trow > TROW_LIM;
  assign w_pick_dbg = bus.dbg_req && (!bus.bg_req || !r_last_dbg);
  assign w_unused   = bus.bg_trow[0] ^ bus.bg_tcol[0];

  assign o_rom_addr   = r_rom_addr;
  assign o_busy       = r_busy;
  assign bus.bg_ack   = r_bg_ack;
  assign bus.bg_pal   = r_bg_pal;
  assign bus.dbg_ack  = r_dbg_ack;
  assign bus.dbg_data = r_dbg_data;

  // next-state and next-output decode; everything holds unless a transition updates it
  always_comb begin
    w_state    = r_state;
    w_gnt_dbg  = r_gnt_dbg;
    w_last_dbg = r_last_dbg;
    w_sel      = r_sel;
    w_rom_addr = r_rom_addr;
    w_bg_ack   = 1'b0;
    w_bg_pal   = r_bg_pal;
    w_dbg_ack  = 1'b0;
    w_dbg_data = r_dbg_data;
`ifdef ATABLE_CACHE_EN
    w_c_vld    = r_c_vld;
    w_c_tag    = r_c_tag;
    w_c_data   = r_c_data;
`endif
    case (r_state)
      IDLE: if (bus.bg_req || bus.dbg_req) begin
        w_gnt_dbg  = w_pick_dbg;
        w_last_dbg = w_pick_dbg;
        if (w_pick_dbg) begin
          w_rom_addr = bus.dbg_addr;
          w_state    = RD;
        end else if (w_oor) begin
          w_bg_pal = 2'b00;
          w_bg_ack = 1'b1;
          w_state  = ACK;
        end
`ifdef ATABLE_CACHE_EN
        else if (r_c_vld && r_c_tag == w_bg_addr) begin
          w_bg_pal = f_pal(r_c_data, w_bg_sel);
          w_bg_ack = 1'b1;
          w_state  = ACK;
        end
`endif
        else begin
          w_sel      = w_bg_sel;
          w_rom_addr = w_bg_addr;
          w_state    = RD;
        end
      end
      RD: w_state = CAP;
      CAP: begin
        w_state = ACK;
        if (r_gnt_dbg) begin
          w_dbg_data = i_rom_dout;
          w_dbg_ack  = 1'b1;
        end else begin
          w_bg_pal = f_pal(i_rom_dout, r_sel);
          w_bg_ack = 1'b1;
`ifdef ATABLE_CACHE_EN
          w_c_vld  = 1'b1;
          w_c_tag  = r_rom_addr;
          w_c_data = i_rom_dout;
`endif
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // state and registered outputs; last grant starts as debug so bg wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt_dbg  <= 1'b0;
      r_last_dbg <= 1'b1;
      r_sel      <= '0;
      r_rom_addr <= '0;
      r_bg_ack   <= 1'b0;
      r_bg_pal   <= '0;
      r_dbg_ack  <= 1'b0;
      r_dbg_data <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_gnt_dbg  <= w_gnt_dbg;
      r_last_dbg <= w_last_dbg;
      r_sel      <= w_sel;
      r_rom_addr <= w_rom_addr;
      r_bg_ack   <= w_bg_ack;
      r_bg_pal   <= w_bg_pal;
      r_dbg_ack  <= w_dbg_ack;
      r_dbg_data <= w_dbg_data;
      r_busy     <= w_state != IDLE;
    end
  end

`ifdef ATABLE_CACHE_EN
  // single-entry cache of the last background ROM byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_vld  <= 1'b0;
      r_c_tag  <= '0;
      r_c_data <= '0;
    end else begin
      r_c_vld  <= w_c_vld;
      r_c_tag  <= w_c_tag;
      r_c_data <= w_c_data;
    end
  end
`endif
endmodule

// File: tb/tb_atable_fetch_ctrl.sv
// tb_atable_fetch_ctrl: directed checks of arbitration, latency, palette extraction and reset abort
module tb_atable_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] rom_addr;
  logic [7:0] rom_dout;
  logic       busy;
  logic [7:0] mem [128];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_pal = 2'b00;
  logic [7:0] exp_dbg = 8'h00;

`ifdef ATABLE_CACHE_EN
  localparam int         HL = 1;
  localparam logic [6:0] LAST_ADDR = 7'h42;
`else
  localparam int         HL = 3;
  localparam logic [6:0] LAST_ADDR = 7'h15;
`endif

  atable_fetch_if bus ();

  atable_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_rom_addr (rom_addr),
    .i_rom_dout (rom_dout),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_dout <= mem[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bg_fetch(input logic nt, input logic [4:0] tr, input logic [4:0] tc,
                          input int lat, input logic [1:0] pal, input logic [6:0] addr);
    int n = 0;
    bus.bg_nt = nt;
    bus.bg_trow = tr;
    bus.bg_tcol = tc;
    bus.bg_req = 1'b1;
    do begin
      step();
      n++;
      if (n == 1) begin
        chk("bg_busy", busy, 1);
        bus.bg_nt = ~nt;
        bus.bg_tcol = ~tc;
        bus.bg_trow = 5'd31;
      end
    end while (!bus.bg_ack && n < 10);
    chk("bg_latency", n, lat);
    chk("bg_pal", bus.bg_pal, pal);
    chk("bg_rom_addr", rom_addr, addr);
    chk("bg_dbg_data_hold", bus.dbg_data, exp_dbg);
    chk("bg_no_dbg_ack", bus.dbg_ack, 0);
    bus.bg_req = 1'b0;
    exp_pal = pal;
    step();
    chk("bg_ack_pulse", bus.bg_ack, 0);
    chk("bg_idle", busy, 0);
  endtask

  task automatic dbg_fetch(input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    bus.dbg_addr = a;
    bus.dbg_req = 1'b1;
    do begin
      step();
      n++;
      if (n == 1) bus.dbg_addr = ~a;
    end while (!bus.dbg_ack && n < 10);
    chk("dbg_latency", n, 3);
    chk("dbg_data", bus.dbg_data, d);
    chk("dbg_rom_addr", rom_addr, a);
    chk("dbg_bg_pal_hold", bus.bg_pal, exp_pal);
    chk("dbg_no_bg_ack", bus.bg_ack, 0);
    bus.dbg_req = 1'b0;
    exp_dbg = d;
    step();
    chk("dbg_ack_pulse", bus.dbg_ack, 0);
    chk("dbg_idle", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_pal = 2'b00;
    exp_dbg = 8'h00;
  endtask

  initial begin
    int got;
    int seen_ack;
    logic [3:0] rr_exp;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h15] = 8'h51;
    mem[7'h42] = 8'h88;
    bus.bg_req = 1'b0;
    bus.bg_nt = 1'b0;
    bus.bg_tcol = 5'd0;
    bus.bg_trow = 5'd0;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = 7'h00;
    step();
    step();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_bg_ack", bus.bg_ack, 0);
    chk("rst_bg_pal", bus.bg_pal, 0);
    chk("rst_dbg_ack", bus.dbg_ack, 0);
    chk("rst_dbg_data", bus.dbg_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    bg_fetch(1'b0, 5'd8, 5'd20, 3, 2'b01, 7'h15);
    bg_fetch(1'b0, 5'd8, 5'd22, HL, 2'b00, 7'h15);
    bg_fetch(1'b0, 5'd10, 5'd22, HL, 2'b01, 7'h15);
    dbg_fetch(7'h42, 8'h88);
    bg_fetch(1'b1, 5'd0, 5'd10, 3, 2'b10, 7'h42);
    bg_fetch(1'b0, 5'd30, 5'd4, 1, 2'b00, 7'h42);
    bus.bg_nt = 1'b0;
    bus.bg_trow = 5'd8;
    bus.bg_tcol = 5'd20;
    bus.bg_req = 1'b1;
    step();
    chk("abort_busy_rd", busy, 1);
    chk("abort_rom_addr_rd", rom_addr, 7'h15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rom_addr", rom_addr, 0);
    chk("abort_bg_pal", bus.bg_pal, 0);
    chk("abort_dbg_data", bus.dbg_data, 0);
    chk("abort_busy", busy, 0);
    bus.bg_req = 1'b0;
    step();
    rst_n = 1'b1;
    exp_pal = 2'b00;
    exp_dbg = 8'h00;
    seen_ack = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.bg_ack || bus.dbg_ack) seen_ack++;
    end
    chk("abort_no_ack", seen_ack, 0);
    bus.dbg_addr = 7'h42;
    bus.bg_req = 1'b1;
    bus.dbg_req = 1'b1;
    rr_exp = 4'b1010;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      step();
      if (bus.bg_ack || bus.dbg_ack) begin
        chk("rr_order", bus.dbg_ack, rr_exp[got]);
        chk("rr_single_ack", bus.bg_ack & bus.dbg_ack, 0);
        if (bus.bg_ack) chk("rr_bg_pal", bus.bg_pal, 2'b01);
        else chk("rr_dbg_data", bus.dbg_data, 8'h88);
        got++;
        if (got == 4) begin
          bus.bg_req = 1'b0;
          bus.dbg_req = 1'b0;
        end
      end
    end
    chk("rr_count", got, 4);
    step();
    chk("rr_idle", busy, 0);
    do_reset();
    step();
    bg_fetch(1'b0, 5'd8, 5'd20, 3, 2'b01, 7'h15);
    dbg_fetch(7'h42, 8'h88);
    bg_fetch(1'b0, 5'd10, 5'd22, HL, 2'b01, LAST_ADDR);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
